// File: rtl/apb_bus_master_pkg.sv
// Shared types for the APB bus master: default address width, FSM encoding, command record.
package apb_bus_master_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int CMD_W      = DEF_ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  wdata;
    } cmd_t;

endpackage

// File: rtl/apb_bus_master_if.sv
// Command/response handshake plus APB pins between the host-side master and the APB slave.
interface apb_bus_master_if
    import apb_bus_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_wdata;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_data;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWDATA;
    logic              PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x W; data visible at the head the cycle after push.
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps the count.
module apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] PTR_ONE  = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_bus_master.sv
// APB master: queued commands -> SETUP/ACCESS transfers, PSEL two edges after push, read rsp two edges later.
// cmd_ready = FIFO not full; rsp is an unthrottled pulse. APB_MST_IRQ_LATCH_EN selects sticky vs level irq.
module apb_bus_master
    import apb_bus_master_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic             SYSCLK,
    input  logic             RST,
    apb_bus_master_if.master bus,
    output logic             irq,
    input  logic             irq_clr,
    output logic             RST_B,
    input  logic             INT_B
);
    localparam int CW = ADDR_W + 2;

    apb_state_t        state;
    logic [CW-1:0]     fifo_din;
    logic [CW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              pend_q;
    logic              rst_b_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic              pwdata_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic              rsp_data_q;
    logic              irq_q;

    assign fifo_din      = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    assign bus.cmd_ready = !fifo_full;

    // IDLE launches only once a command has sat in the FIFO for a full cycle.
    assign fifo_pop = ((state == IDLE) && pend_q && rst_b_q && !fifo_empty) ||
                      ((state == ACCESS) && !fifo_empty);

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (SYSCLK),
        .rst   (RST),
        .push  (bus.cmd_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state       <= IDLE;
            pend_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 1'b0;
            paddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= 1'b0;
        end else begin
            pend_q      <= !fifo_empty;
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        pwrite_q <= fifo_dout[CW-1];
                        paddr_q  <= fifo_dout[CW-2:1];
                        pwdata_q <= fifo_dout[0];
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (!pwrite_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_addr_q  <= paddr_q;
                        rsp_data_q  <= bus.PRDATA;
                    end
                    penable_q <= 1'b0;
                    if (fifo_pop) begin
                        pwrite_q <= fifo_dout[CW-1];
                        paddr_q  <= fifo_dout[CW-2:1];
                        pwdata_q <= fifo_dout[0];
                        state    <= SETUP;
                    end else begin
                        psel_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        rst_b_q <= ~RST;
    end

`ifdef APB_MST_IRQ_LATCH_EN
    logic int_b_q;

    // A fresh falling edge outranks a same-cycle clear.
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            int_b_q <= 1'b1;
            irq_q   <= 1'b0;
        end else begin
            int_b_q <= INT_B;
            irq_q   <= (int_b_q && !INT_B) || (irq_q && !irq_clr);
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;

    always_ff @(posedge SYSCLK) begin
        if (RST) irq_q <= 1'b0;
        else     irq_q <= ~INT_B;
    end
`endif

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign RST_B         = rst_b_q;
    assign irq           = irq_q;

endmodule
